// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// - state_t      : arbiter FSM states
// - port_id_t    : which requester owns the issue register
// - SZ_*         : access size encodings carried in ctrl[1:0]
// - is_misaligned: flags illegal sizes and unaligned half/word accesses
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size 2'b11 has no meaning and is rejected together with misalignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic [1:0] size);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter.
// - req/we/addr/ctrl/wdata : request, driven by the requester (master)
// - gnt                    : combinational accept from the arbiter
// - rvalid/rdata/err       : one-cycle response from the arbiter
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [DATA_WIDTH-1:0] addr;
    logic [2:0]            ctrl;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output req, we, addr, ctrl, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, ctrl, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between two requesters.
// Port p0 (load/store stage) has fixed priority; port p1 (loader/debug)
// is guaranteed progress by a starvation counter. Each accepted request is
// registered, drives memory for one cycle (ACCESS) and is answered one cycle
// later (RESP). Misaligned/illegal requests never write memory.
// Ports:
// - clk, rst        : clock, synchronous active-high reset
// - p0, p1          : requester buses (slave side)
// - mem_a/mem_we/mem_ctrl/mem_wd : memory command, valid in ACCESS
// - mem_rd          : combinational memory read data
// - busy            : FSM not idle
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_arbiter_if.slave         p0,
    dmem_arbiter_if.slave         p1,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic                  mem_we,
    output logic [2:0]            mem_ctrl,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic                  busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_t                state;
    logic [CNT_W-1:0]      starve_cnt;

    logic                  issue_we;
    logic [DATA_WIDTH-1:0] issue_addr;
    logic [2:0]            issue_ctrl;
    logic [DATA_WIDTH-1:0] issue_wdata;
    port_id_t              issue_port;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  accept_window;
    logic                  starved;
    logic                  p0_win;
    logic                  p1_win;
    logic                  accept;
    logic                  issue_err;
    logic                  resp;

    // Accept decision: only from IDLE/RESP, never during reset.
    always_comb begin
        accept_window = !rst && (state == IDLE || state == RESP);
        starved       = (starve_cnt == CNT_MAX);
        p1_win        = accept_window && p1.req && (starved || !p0.req);
        p0_win        = accept_window && p0.req && !p1_win;
        accept        = p0_win || p1_win;
        issue_err     = is_misaligned(issue_addr[1:0], issue_ctrl[1:0]);
        resp          = !rst && (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            issue_we    <= 1'b0;
            issue_addr  <= '0;
            issue_ctrl  <= '0;
            issue_wdata <= '0;
            issue_port  <= PORT0;
            rdata_q     <= '0;
        end else begin
            case (state)
                IDLE:    if (accept) state <= ACCESS;
                ACCESS:  state <= RESP;
                RESP:    state <= accept ? ACCESS : IDLE;
                default: state <= IDLE;
            endcase

            // Issue register: winner's request captured on accept.
            if (p1_win) begin
                issue_we    <= p1.we;
                issue_addr  <= p1.addr;
                issue_ctrl  <= p1.ctrl;
                issue_wdata <= p1.wdata;
                issue_port  <= PORT1;
            end else if (p0_win) begin
                issue_we    <= p0.we;
                issue_addr  <= p0.addr;
                issue_ctrl  <= p0.ctrl;
                issue_wdata <= p0.wdata;
                issue_port  <= PORT0;
            end

            // Response data: stores and rejected accesses answer with zero.
            if (state == ACCESS)
                rdata_q <= (issue_we || issue_err) ? '0 : mem_rd;

            // p0 winning while p1 waits is a lost opportunity for p1.
            if (!p1.req || p1_win)
                starve_cnt <= '0;
            else if (p0_win && starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign p0.gnt    = p0_win;
    assign p1.gnt    = p1_win;

    assign p0.rvalid = resp && (issue_port == PORT0);
    assign p1.rvalid = resp && (issue_port == PORT1);
    assign p0.err    = p0.rvalid && issue_err;
    assign p1.err    = p1.rvalid && issue_err;
    assign p0.rdata  = p0.rvalid ? rdata_q : '0;
    assign p1.rdata  = p1.rvalid ? rdata_q : '0;

    // Memory command always reflects the issue register; only the write
    // enable is qualified, and a reset edge cancels a pending store.
    assign mem_a     = issue_addr;
    assign mem_ctrl  = issue_ctrl;
    assign mem_wd    = issue_wdata;
    assign mem_we    = (state == ACCESS) && issue_we && !issue_err && !rst;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [2:0]  mem_ctrl;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        busy;

    dmem_arbiter_if #(.DATA_WIDTH(32)) p0_if ();
    dmem_arbiter_if #(.DATA_WIDTH(32)) p1_if ();

    dmem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .p0      (p0_if),
        .p1      (p1_if),
        .mem_a   (mem_a),
        .mem_we  (mem_we),
        .mem_ctrl(mem_ctrl),
        .mem_wd  (mem_wd),
        .mem_rd  (mem_rd),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Memory model: 128 KiB, little-endian, sized/extended reads.
    logic [7:0]  mem [0:131071];
    logic        bd_we;
    logic [16:0] bd_addr;
    logic [31:0] bd_data;
    int          we_cnt = 0;
    int          both_gnt = 0;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr]         <= bd_data[7:0];
            mem[bd_addr + 17'd1] <= bd_data[15:8];
            mem[bd_addr + 17'd2] <= bd_data[23:16];
            mem[bd_addr + 17'd3] <= bd_data[31:24];
        end
        if (mem_we) begin
            we_cnt <= we_cnt + 1;
            mem[mem_a[16:0]] <= mem_wd[7:0];
            if (mem_ctrl[1:0] != 2'b00)
                mem[mem_a[16:0] + 17'd1] <= mem_wd[15:8];
            if (mem_ctrl[1:0] == 2'b10) begin
                mem[mem_a[16:0] + 17'd2] <= mem_wd[23:16];
                mem[mem_a[16:0] + 17'd3] <= mem_wd[31:24];
            end
        end
        if (p0_if.gnt && p1_if.gnt)
            both_gnt <= both_gnt + 1;
    end

    always_comb begin
        logic [16:0] ra;
        ra     = mem_a[16:0];
        mem_rd = '0;
        case (mem_ctrl[1:0])
            2'b00: mem_rd = mem_ctrl[2] ? {24'h0, mem[ra]}
                                        : {{24{mem[ra][7]}}, mem[ra]};
            2'b01: mem_rd = mem_ctrl[2] ? {16'h0, mem[ra + 17'd1], mem[ra]}
                                        : {{16{mem[ra + 17'd1][7]}}, mem[ra + 17'd1], mem[ra]};
            default: mem_rd = {mem[ra + 17'd3], mem[ra + 17'd2], mem[ra + 17'd1], mem[ra]};
        endcase
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd_word(input logic [16:0] a);
        return {mem[a + 17'd3], mem[a + 17'd2], mem[a + 17'd1], mem[a]};
    endfunction

    task automatic bd_write(input logic [16:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        tick;
        bd_we   = 1'b0;
    endtask

    task automatic set_req(input int p, input logic we, input logic [31:0] a,
                           input logic [2:0] c, input logic [31:0] wd);
        if (p == 0) begin
            p0_if.we = we; p0_if.addr = a; p0_if.ctrl = c; p0_if.wdata = wd; p0_if.req = 1'b1;
        end else begin
            p1_if.we = we; p1_if.addr = a; p1_if.ctrl = c; p1_if.wdata = wd; p1_if.req = 1'b1;
        end
    endtask

    task automatic clr_req(input int p);
        if (p == 0) p0_if.req = 1'b0;
        else        p1_if.req = 1'b0;
    endtask

    // One transaction from IDLE: gnt in the request cycle, nothing in
    // ACCESS, response two cycles after the grant; ends back in IDLE.
    task automatic single(input int p, input logic we, input logic [31:0] a,
                          input logic [2:0] c, input logic [31:0] wd,
                          output logic g, output logic arv, output logic rv,
                          output logic [31:0] rd, output logic er, output logic orv);
        set_req(p, we, a, c, wd);
        #1;
        g = (p == 0) ? p0_if.gnt : p1_if.gnt;
        tick;
        clr_req(p);
        arv = (p == 0) ? p0_if.rvalid : p1_if.rvalid;
        tick;
        rv  = (p == 0) ? p0_if.rvalid : p1_if.rvalid;
        rd  = (p == 0) ? p0_if.rdata  : p1_if.rdata;
        er  = (p == 0) ? p0_if.err    : p1_if.err;
        orv = (p == 0) ? p1_if.rvalid : p0_if.rvalid;
        tick;
    endtask

    logic        g, arv, rv, er, orv;
    logic [31:0] rd;
    int          we_snap;
    int          wins[$];
    int          exp_win[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        p0_if.req = 0; p0_if.we = 0; p0_if.addr = 0; p0_if.ctrl = 0; p0_if.wdata = 0;
        p1_if.req = 0; p1_if.we = 0; p1_if.addr = 0; p1_if.ctrl = 0; p1_if.wdata = 0;
        tick;
        tick;

        // Reset: request present but nothing granted, nothing active.
        p0_if.req = 1'b1;
        p1_if.req = 1'b1;
        #1;
        chk("rst_p0_gnt", 32'(p0_if.gnt), 32'd0);
        chk("rst_p1_gnt", 32'(p1_if.gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_p0_rvalid", 32'(p0_if.rvalid), 32'd0);
        tick;
        rst = 1'b0;
        p0_if.req = 1'b0;
        p1_if.req = 1'b0;

        bd_write(17'h100, 32'hDEADBEEF);
        bd_write(17'h020, 32'h77777700);
        bd_write(17'h040, 32'hCAFEF00D);

        // Single load on p0.
        single(0, 1'b0, 32'h100, 3'b010, 32'h0, g, arv, rv, rd, er, orv);
        chk("lw_gnt", 32'(g), 32'd1);
        chk("lw_rvalid_early", 32'(arv), 32'd0);
        chk("lw_rvalid", 32'(rv), 32'd1);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", 32'(er), 32'd0);
        chk("lw_other_rvalid", 32'(orv), 32'd0);
        chk("lw_idle", 32'(busy), 32'd0);

        // Byte store then signed/unsigned byte loads on p1.
        single(1, 1'b1, 32'h20, 3'b000, 32'h1A5, g, arv, rv, rd, er, orv);
        chk("sb_gnt", 32'(g), 32'd1);
        chk("sb_rvalid", 32'(rv), 32'd1);
        chk("sb_rdata", rd, 32'h0);
        chk("sb_mem", rd_word(17'h20), 32'h777777A5);
        single(1, 1'b0, 32'h20, 3'b100, 32'h0, g, arv, rv, rd, er, orv);
        chk("lbu_rdata", rd, 32'h000000A5);
        single(1, 1'b0, 32'h20, 3'b000, 32'h0, g, arv, rv, rd, er, orv);
        chk("lb_rdata", rd, 32'hFFFFFFA5);
        chk("lb_other_rvalid", 32'(orv), 32'd0);

        // Misaligned accesses are answered with err and never write.
        we_snap = we_cnt;
        single(0, 1'b0, 32'h102, 3'b010, 32'h0, g, arv, rv, rd, er, orv);
        chk("mis_lw_rvalid", 32'(rv), 32'd1);
        chk("mis_lw_err", 32'(er), 32'd1);
        chk("mis_lw_rdata", rd, 32'h0);
        single(0, 1'b1, 32'h101, 3'b001, 32'h1234, g, arv, rv, rd, er, orv);
        chk("mis_sh_err", 32'(er), 32'd1);
        chk("mis_sh_mem", rd_word(17'h100), 32'hDEADBEEF);
        single(0, 1'b0, 32'h100, 3'b011, 32'h0, g, arv, rv, rd, er, orv);
        chk("illegal_err", 32'(er), 32'd1);
        chk("mis_no_we", we_cnt, we_snap);

        // Back-to-back stores with req held: grants two cycles apart.
        set_req(0, 1'b1, 32'h0, 3'b010, 32'h03020100);
        #1;
        chk("b2b_gnt0", 32'(p0_if.gnt), 32'd1);
        tick;
        set_req(0, 1'b1, 32'h4, 3'b010, 32'h07060504);
        #1;
        chk("b2b_access_gnt", 32'(p0_if.gnt), 32'd0);
        tick;
        chk("b2b_rvalid0", 32'(p0_if.rvalid), 32'd1);
        chk("b2b_gnt1", 32'(p0_if.gnt), 32'd1);
        tick;
        set_req(0, 1'b1, 32'h8, 3'b010, 32'h0B0A0908);
        #1;
        chk("b2b_access_gnt2", 32'(p0_if.gnt), 32'd0);
        tick;
        chk("b2b_rvalid1", 32'(p0_if.rvalid), 32'd1);
        chk("b2b_gnt2", 32'(p0_if.gnt), 32'd1);
        tick;
        clr_req(0);
        tick;
        chk("b2b_rvalid2", 32'(p0_if.rvalid), 32'd1);
        tick;
        chk("b2b_idle", 32'(busy), 32'd0);
        chk("b2b_mem0", rd_word(17'h0), 32'h03020100);
        chk("b2b_mem4", rd_word(17'h4), 32'h07060504);
        chk("b2b_mem8", rd_word(17'h8), 32'h0B0A0908);

        // Contention: both ports request continuously.
        set_req(0, 1'b0, 32'h100, 3'b010, 32'h0);
        set_req(1, 1'b0, 32'h20, 3'b010, 32'h0);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (p0_if.gnt) wins.push_back(0);
            if (p1_if.gnt) wins.push_back(1);
            if (i == 19) begin
                clr_req(0);
                clr_req(1);
            end
            tick;
        end
        tick;
        chk("cont_grants", wins.size(), 32'd10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("cont_win%0d", k), (k < wins.size()) ? wins[k] : 99, exp_win[k]);
        chk("cont_both_gnt", both_gnt, 32'd0);

        // Reset during the ACCESS of a p1 store: store dropped, no response.
        set_req(1, 1'b1, 32'h40, 3'b010, 32'h12345678);
        #1;
        chk("rstmid_gnt", 32'(p1_if.gnt), 32'd1);
        tick;
        rst = 1'b1;
        clr_req(1);
        #1;
        chk("rstmid_mem_we", 32'(mem_we), 32'd0);
        chk("rstmid_rvalid", 32'(p1_if.rvalid), 32'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_no_resp", 32'(p1_if.rvalid), 32'd0);
        tick;
        chk("rstmid_no_resp2", 32'(p1_if.rvalid), 32'd0);
        chk("rstmid_mem", rd_word(17'h40), 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
